// File: rtl/bin_to_seg_pkg.sv
// Shared types and constants for the sequential binary-to-7-segment driver.
// Segment patterns are active-low, bit order {a,b,c,d,e,f,g} from MSB to LSB.
package bin_to_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0001100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Smallest digit count d with 10^d > 2^width - 1.
  function automatic int min_digits(input int width);
    longint pow10;
    int     d;
    pow10 = 10;
    d     = 1;
    for (int i = 0; i < 12; i++) begin
      if (pow10 < (longint'(1) << width)) begin
        pow10 = pow10 * 10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_to_seg_seq_seg7_digit.sv
// Single-digit active-low 7-segment decoder; non-decimal nibbles or an
// asserted blank input produce an unlit digit.
module seg7_digit
  import bin_to_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (nibble <= 4'd9)) begin
      seg = SEG_DIGIT[nibble];
    end
  end

endmodule

// File: rtl/bin_to_seg_seq.sv
// Iterative double-dabble converter (one bit per clock) feeding DIGITS
// 7-segment decoders, with start/busy/done handshake and leading-zero blanking.
module bin_to_seg_seq
  import bin_to_seg_pkg::*;
#(
  parameter int IN_WIDTH      = 8,
  parameter int DIGITS        = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  if ((IN_WIDTH < 1) || (IN_WIDTH > 20)) begin : g_bad_width
    $fatal(1, "bin_to_seg_seq: IN_WIDTH must be within 1..20");
  end
  if (DIGITS < min_digits(IN_WIDTH)) begin : g_bad_digits
    $fatal(1, "bin_to_seg_seq: DIGITS too small to hold 2^IN_WIDTH-1");
  end

  state_t                state_reg;
  logic [IN_WIDTH-1:0]   shift_reg;
  logic [4*DIGITS-1:0]   acc_reg;
  logic [CNT_W-1:0]      count_reg;

  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_next;
  logic [DIGITS-1:0]     blank_next;
  logic [7*DIGITS-1:0]   seg_next;
  logic                  zero_run;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ? acc_reg[4*gi +: 4] + 4'd3
                                                                : acc_reg[4*gi +: 4];
      // Decoders watch the post-shift accumulator so seg can be latched on the last shift.
      seg7_digit u_seg7_digit (
        .nibble (acc_next[4*gi +: 4]),
        .blank  (blank_next[gi]),
        .seg    (seg_next[7*gi +: 7])
      );
    end
  endgenerate

  assign acc_next = {acc_adj[4*DIGITS-2:0], shift_reg[IN_WIDTH-1]};

  // A digit blanks only while it and every higher digit are zero; units always shows.
  always_comb begin
    zero_run   = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (acc_next[4*i +: 4] == 4'd0);
      blank_next[i] = (BLANK_LEADING != 0) && zero_run && (i != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      seg       <= '1;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg <= bin_in;
            acc_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= ST_SHIFT;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_reg << 1;
          count_reg <= count_reg + CNT_W'(1);
          if (count_reg == LAST_CNT) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            bcd       <= acc_next;
            seg       <= seg_next;
            state_reg <= ST_DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_seg_seq.sv
// Randomised and directed bench for bin_to_seg_seq: three instances cover the
// default configuration, no blanking, and the legacy 4-bit/2-digit width.
module tb_bin_to_seg_seq;

  localparam logic [6:0] SEG_PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b, start_c;
  logic [7:0]  bin_a, bin_b;
  logic [3:0]  bin_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [11:0] bcd_a, bcd_b;
  logic [7:0]  bcd_c;
  logic [20:0] seg_a, seg_b;
  logic [13:0] seg_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_seg_seq #(.IN_WIDTH(8), .DIGITS(3), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .seg(seg_a)
  );

  bin_to_seg_seq #(.IN_WIDTH(8), .DIGITS(3), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .seg(seg_b)
  );

  bin_to_seg_seq #(.IN_WIDTH(4), .DIGITS(2), .BLANK_LEADING(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .bin_in(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .seg(seg_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_bcd(input int v, input int digits);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_seg(input int v, input int digits, input bit blank_lead);
    logic [31:0] r;
    int          pw;
    r  = '0;
    pw = 1;
    for (int i = 0; i < digits; i++) begin
      if (blank_lead && (i > 0) && (v < pw)) r[7*i +: 7] = 7'b1111111;
      else                                   r[7*i +: 7] = SEG_PAT[(v / pw) % 10];
      pw = pw * 10;
    end
    return r;
  endfunction

  // Starts all three instances on the same value and watches a fixed window.
  task automatic convert(input int value);
    int          cyc_a, cyc_b, cyc_c, n_a, n_b, n_c, busy_cnt;
    logic [11:0] bcd_a_s, bcd_b_s;
    logic [20:0] seg_a_s, seg_b_s;
    logic [7:0]  bcd_c_s;
    logic [13:0] seg_c_s;
    cyc_a = -1; cyc_b = -1; cyc_c = -1;
    n_a = 0; n_b = 0; n_c = 0; busy_cnt = 0;
    bcd_a_s = '0; bcd_b_s = '0; bcd_c_s = '0;
    seg_a_s = '0; seg_b_s = '0; seg_c_s = '0;
    bin_a = 8'(value); bin_b = 8'(value); bin_c = 4'(value);
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      busy_cnt += int'(busy_a);
      if (done_a) begin n_a++; cyc_a = cyc; bcd_a_s = bcd_a; seg_a_s = seg_a; end
      if (done_b) begin n_b++; cyc_b = cyc; bcd_b_s = bcd_b; seg_b_s = seg_b; end
      if (done_c) begin n_c++; cyc_c = cyc; bcd_c_s = bcd_c; seg_c_s = seg_c; end
      bin_a = 8'($urandom); bin_b = 8'($urandom); bin_c = 4'($urandom);
    end
    $display("convert %0d: bcd_a=%03h seg_a=%06h seg_b=%06h bcd_c=%02h seg_c=%04h",
             value, bcd_a_s, seg_a_s, seg_b_s, bcd_c_s, seg_c_s);
    check_eq("a_done_cycle", cyc_a, 9);
    check_eq("a_done_pulses", n_a, 1);
    check_eq("a_busy_cycles", busy_cnt, 8);
    check_eq("a_bcd", bcd_a_s, model_bcd(value % 256, 3));
    check_eq("a_seg", seg_a_s, model_seg(value % 256, 3, 1'b1));
    check_eq("b_done_cycle", cyc_b, 9);
    check_eq("b_done_pulses", n_b, 1);
    check_eq("b_seg", seg_b_s, model_seg(value % 256, 3, 1'b0));
    check_eq("c_done_cycle", cyc_c, 5);
    check_eq("c_done_pulses", n_c, 1);
    check_eq("c_bcd", bcd_c_s, model_bcd(value % 16, 2));
    check_eq("c_seg", seg_c_s, model_seg(value % 16, 2, 1'b1));
  endtask

  // 99 at cycle 0, ignored 200 mid-shift, 42 requested during the DONE cycle.
  task automatic back_to_back_test();
    int          n_done, cyc1, cyc2;
    logic [11:0] r1, r2;
    n_done = 0; cyc1 = -1; cyc2 = -1; r1 = '0; r2 = '0;
    bin_a = 8'd99; start_a = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a) begin
        n_done++;
        if (n_done == 1) begin
          cyc1 = cyc; r1 = bcd_a; start_a = 1'b1; bin_a = 8'd42;
        end else begin
          cyc2 = cyc; r2 = bcd_a;
        end
      end else if (cyc == 4) begin
        start_a = 1'b1; bin_a = 8'd200;
      end
    end
    $display("back_to_back: done at %0d (%03h) and %0d (%03h), pulses=%0d", cyc1, r1, cyc2, r2, n_done);
    check_eq("b2b_pulses", n_done, 2);
    check_eq("b2b_first_cycle", cyc1, 9);
    check_eq("b2b_second_cycle", cyc2, 18);
    check_eq("b2b_first_bcd", r1, 12'h099);
    check_eq("b2b_second_bcd", r2, 12'h042);
  endtask

  task automatic reset_abort_test();
    int n_done;
    n_done = 0;
    bin_a = 8'd123; start_a = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("reset_abort: busy=%0b done=%0b bcd=%03h seg=%06h", busy_a, done_a, bcd_a, seg_a);
    check_eq("abort_busy", busy_a, 1'b0);
    check_eq("abort_done", done_a, 1'b0);
    check_eq("abort_bcd", bcd_a, 12'h000);
    check_eq("abort_seg", seg_a, 21'h1FFFFF);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      n_done += int'(done_a);
    end
    check_eq("abort_no_done", n_done, 0);
    convert(5);
    check_eq("after_abort_bcd", bcd_a, 12'h005);
  endtask

  initial begin
    int dir_vals [9] = '{255, 0, 10, 7, 99, 123, 5, 15, 3};
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("idle_done", done_a, 1'b0);
    end
    $display("reset: busy=%0b done=%0b bcd=%03h seg=%06h seg_c=%04h", busy_a, done_a, bcd_a, seg_a, seg_c);
    check_eq("reset_busy", busy_a, 1'b0);
    check_eq("reset_bcd", bcd_a, 12'h000);
    check_eq("reset_seg", seg_a, 21'h1FFFFF);
    check_eq("reset_seg_c", seg_c, 14'h3FFF);

    foreach (dir_vals[i]) begin
      convert(dir_vals[i]);
      case (dir_vals[i])
        255: begin
          check_eq("lit255_bcd", bcd_a, 12'h255);
          check_eq("lit255_seg", seg_a, {7'b0010010, 7'b0100100, 7'b0100100});
        end
        0:   check_eq("lit0_seg", seg_a, {7'b1111111, 7'b1111111, 7'b0000001});
        10:  check_eq("lit10_seg", seg_a, {7'b1111111, 7'b1001111, 7'b0000001});
        7:   check_eq("lit7_noblank_seg", seg_b, {7'b0000001, 7'b0000001, 7'b0001111});
        15:  check_eq("lit15_c_seg", seg_c, {7'b1001111, 7'b0100100});
        3:   check_eq("lit3_c_seg", seg_c, {7'b1111111, 7'b0000110});
        default: ;
      endcase
    end

    for (int v = 0; v < 16; v++) convert(v);
    repeat (20) convert(int'($urandom_range(0, 255)));

    back_to_back_test();
    reset_abort_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_seg_seq.md
Name: bin_to_seg_seq

Overview:
Sequential, parametrised binary-to-decimal display driver for the board's multi-digit active-low 7-segment displays. It converts an IN_WIDTH-bit unsigned value into DIGITS BCD digits using iterative double-dabble, one bit per clock. It then drives per-digit segment patterns, with optional leading-zero blanking. A start/busy/done handshake lets a controller or counter feed it values. It replaces the fixed 4-bit, 2-digit combinational decoder for wider values.

Parameters:
IN_WIDTH, 8, width of binary input; legal range 1..20
DIGITS, 3, number of decimal digits; must satisfy 10^DIGITS > 2^IN_WIDTH - 1 (elaboration-time check, fatal on violation)
BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all digits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion of bin_in; sampled only when ready (IDLE or DONE)
bin_in  input  IN_WIDTH  unsigned value, captured in the cycle start is accepted
busy  output  1  high while a conversion is in progress (SHIFT state)
done  output  1  one-cycle pulse; bcd/seg updated in the same cycle
bcd  output  4*DIGITS  BCD result, digit i at [4i+3:4i], digit 0 = units; held until next done
seg  output  7*DIGITS  active-low segments, digit i at [7i+6:7i], bit order {a,b,c,d,e,f,g} MSB->LSB; held until next done

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset values: busy=0, done=0, bcd=0, seg=all ones (all digits blank); FSM=IDLE; shift and count registers cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE: if start=1, capture bin_in into the shift register, clear the BCD accumulator, set count=0, and go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - add 3 to every accumulator nibble >=5;
  - then shift {accumulator, shift register} left by 1;
  - count++.
  - After the IN_WIDTH-th shift, go to DONE.
- DONE: done=1 for exactly this cycle; bcd and seg are registered from the final accumulator at entry to DONE.
  - If start=1 in DONE, accept it: capture and go to SHIFT, back-to-back, with no IDLE cycle.
  - Otherwise go to IDLE.
- Latency: start accepted in cycle 0; done high in cycle IN_WIDTH+1. Throughput is one conversion per IN_WIDTH+1 cycles.
- start while busy=1 is ignored; bin_in changes during SHIFT have no effect.
- Segment encoding (active-low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - blank=1111111
  - Nibbles >9 cannot occur; if they do, the digit decodes to blank.
- Blanking (BLANK_LEADING=1): digit i is blank if it and all higher digits are 0, except digit 0, which is never blanked (value 0 shows "0"). With BLANK_LEADING=0, all digits are decoded.
- bcd is never blanked.
- Reset asserted mid-SHIFT aborts the conversion: no done pulse, and outputs return to reset values the next cycle.
- Reset and start high together: reset wins.

Decomposition:
- Package bin_to_seg_pkg:
  - FSM state enum;
  - SEG_BLANK constant;
  - 10-entry active-low digit pattern constant array;
  - a function to compute the minimum DIGITS for a given IN_WIDTH (used in the elaboration check).
- One sub-module, seg7_digit: combinational 4-bit nibble plus blank input -> 7-bit active-low pattern. It is instantiated DIGITS times via generate.
- The top level holds the FSM, shift/accumulator registers, and blanking logic.

Test Plan:
1. Reset, then idle 5 cycles -> busy=0, done=0, bcd=0x000, seg=all ones.
2. IN_WIDTH=8, DIGITS=3; start with bin_in=255 at cycle 0 -> busy high in cycles 1-8, done pulse in cycle 9, bcd=0x255, seg={0010010,0100100,0100100}.
3. bin_in=0 -> bcd=0x000, seg={1111111,1111111,0000001}; bin_in=10 -> seg={1111111,1001111,0000001}; repeat with BLANK_LEADING=0 and bin_in=7 -> seg={0000001,0000001,0001111}.
4. Start at cycle 0 with 99; pulse start again with 200 at cycle 4; start=1 again in the DONE cycle with 42 -> first result 0x099, second conversion 0x042, done pulses exactly IN_WIDTH+1 cycles apart, and 200 is never converted.
5. Start with 123; assert reset in cycle 4 -> no done pulse, outputs back to reset values the next cycle; a following start with 5 converts correctly to 0x005.
6. IN_WIDTH=4, DIGITS=2; sweep 0..15 -> seg matches the legacy pattern table. Example: 15 -> {1001111,0100100}; 3 -> {1111111,0000110}.
